softmax_log_norm: RTL and testbench

- Downstream consumer of the 14-in/19-out log LUT in the softmax datapath.
- Buffers one vector of max-subtracted scores (x_i − max) and waits for the LUT's log(Σexp) result.
- Then streams y_i = (x_i − max) − log(Σexp), saturated, to the final exp stage.
- Scores and log share the same fixed-point fraction alignment; no shifting is done here.

---
 rtl/softmax_log_norm.sv | 145 ++++++++++++++
 tb/tb_softmax_log_norm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_log_norm.sv
// Softmax log-normalisation stage: buffers one vector of max-subtracted scores,
// waits for log(sum(exp)) from the LUT, then streams saturated (x_i - log) values.
module softmax_log_norm #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned LOG_W  = 19,
    parameter int unsigned OUT_W  = 19,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              log_valid,
    output logic              log_ready,
    input  logic [LOG_W-1:0]  log_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DIFF_W = ((DATA_W > LOG_W) ? DATA_W : LOG_W) + 1;
    localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] SAT_MIN = DIFF_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        FILL,
        WAIT_LOG,
        DRAIN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    rd_q;
    logic [LOG_W-1:0]    log_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_fire_c;
    logic                load_c;
    logic                last_fire_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic signed [DIFF_W-1:0] diff_c;
    logic [OUT_W-1:0]    sat_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake readies
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        log_ready = 1'b0;
        in_fire_c = 1'b0;
        case (state_q)
            FILL: begin
                in_ready  = !rst;
                in_fire_c = in_valid && !rst;
                if (in_fire_c && (in_last || (count_q == CNT_W'(DEPTH - 1)))) begin
                    state_d = WAIT_LOG;
                end
            end
            WAIT_LOG: begin
                log_ready = !rst;
                if (log_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_fire_c) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign busy        = (state_q != FILL) || (count_q != '0);
    assign last_fire_c = (state_q == DRAIN) && out_valid && out_ready && out_last;
    // Refill the output register whenever it is empty or being consumed: no bubbles
    assign load_c      = (state_q == DRAIN) && (rd_q < count_q) && (!out_valid || out_ready);
    assign rd_data_c   = mem[rd_q[ADDR_W-1:0]];

    // Sign-extended subtract with clamp to the output range
    always_comb begin
        diff_c = DIFF_W'($signed(rd_data_c)) - DIFF_W'($signed(log_q));
        if (diff_c > SAT_MAX) begin
            sat_c = OUT_W'(SAT_MAX);
        end else if (diff_c < SAT_MIN) begin
            sat_c = OUT_W'(SAT_MIN);
        end else begin
            sat_c = OUT_W'(diff_c);
        end
    end

    // Score buffer; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (in_fire_c) begin
            mem[count_q[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rd_q      <= '0;
            log_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire_c) begin
                count_q <= count_q + CNT_W'(1);
            end
            if ((state_q == WAIT_LOG) && log_valid) begin
                log_q <= log_in;
                rd_q  <= '0;
            end
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= sat_c;
                out_last  <= (rd_q == (count_q - CNT_W'(1)));
                rd_q      <= rd_q + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (last_fire_c) begin
                count_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_softmax_log_norm.sv
// Self-checking bench for softmax_log_norm: directed table, random vectors
// against a clamp-arithmetic model, and hand-written corner sequences.
module tb_softmax_log_norm;

    localparam int DATA_W = 19;
    localparam int LOG_W  = 19;
    localparam int OUT_W  = 19;
    localparam int DEPTH  = 16;
    localparam int NTAB   = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DATA_W-1:0] in_data;
    logic             in_last;
    logic             log_valid;
    logic             log_ready;
    logic [LOG_W-1:0] log_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int n;
        bit use_last;
        int lg;
        int mode;
        int x[16];
        int y[16];
    } vec_t;

    vec_t tbl[NTAB];
    vec_t hv;

    softmax_log_norm dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .log_valid(log_valid), .log_ready(log_ready), .log_in(log_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic int model(input int x, input int l);
        int d;
        d = x - l;
        if (d > 262143) return 262143;
        if (d < -262144) return -262144;
        return d;
    endfunction

    // Present every score of v; returns at a negedge in WAIT_LOG
    task automatic send_vector(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            int g;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DATA_W'(v.x[i]);
            in_last  = v.use_last && (i == v.n - 1);
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) check("in_ready timeout", 0, 1);
            check("log_ready during fill", int'(log_ready), 0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready in wait_log", int'(in_ready), 0);
        check("log_ready in wait_log", int'(log_ready), 1);
    endtask

    // Offer the log value; returns right after the capture edge
    task automatic send_log(input int lg);
        int g;
        log_valid = 1'b1;
        log_in    = LOG_W'(lg);
        g = 0;
        while (!log_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("log_ready timeout", 0, 1);
        @(posedge clk);
    endtask

    // Consume results; mode 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic recv(input vec_t v, input int stop_after);
        int  got = 0;
        int  cyc = 0;
        int  first = -1;
        bit  pv = 1'b0;
        bit  pr = 1'b0;
        int  pd = 0;
        int  pl = 0;
        bit  rdy;
        while (got < stop_after && cyc < 400) begin
            @(negedge clk);
            log_valid = 1'b0;
            case (v.mode)
                0: rdy = 1'b1;
                1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            check("in_ready during drain", int'(in_ready), 0);
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (pv && !pr) begin
                    check("stall data stable", $signed(out_data), pd);
                    check("stall last stable", int'(out_last), pl);
                end
                if (rdy) begin
                    check($sformatf("data elem %0d", got), $signed(out_data), v.y[got]);
                    check($sformatf("last elem %0d", got), int'(out_last), int'(got == v.n - 1));
                    got++;
                end
            end
            pv = out_valid;
            pr = rdy;
            pd = $signed(out_data);
            pl = int'(out_last);
            cyc++;
            @(posedge clk);
        end
        check("results received", got, stop_after);
        check("first out_valid latency", first, 1);
        if (stop_after == v.n) begin
            if (v.mode == 0) check("drain cycles", cyc - first, v.n);
            @(negedge clk);
            out_ready = 1'b0;
            check("out_valid after last", int'(out_valid), 0);
            check("busy after last", int'(busy), 0);
            check("in_ready after last", int'(in_ready), 1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        log_valid = 1'b0; log_in = '0; out_ready = 1'b0;

        tbl[0].n = 4; tbl[0].use_last = 1; tbl[0].lg = 1000; tbl[0].mode = 0;
        tbl[0].x[0] = 0; tbl[0].x[1] = -256; tbl[0].x[2] = -512; tbl[0].x[3] = -1024;
        tbl[0].y[0] = -1000; tbl[0].y[1] = -1256; tbl[0].y[2] = -1512; tbl[0].y[3] = -2024;
        tbl[1].n = 1; tbl[1].use_last = 1; tbl[1].lg = 100000; tbl[1].mode = 0;
        tbl[1].x[0] = -200000; tbl[1].y[0] = -262144;
        tbl[2].n = 1; tbl[2].use_last = 1; tbl[2].lg = -5000; tbl[2].mode = 0;
        tbl[2].x[0] = 262000; tbl[2].y[0] = 262143;
        tbl[3].n = 16; tbl[3].use_last = 0; tbl[3].lg = 16; tbl[3].mode = 0;
        for (int i = 0; i < 16; i++) begin
            tbl[3].x[i] = i + 1;
            tbl[3].y[i] = i - 15;
        end
        tbl[4].n = 4; tbl[4].use_last = 1; tbl[4].lg = -3; tbl[4].mode = 1;
        tbl[4].x[0] = 10; tbl[4].x[1] = 20; tbl[4].x[2] = 30; tbl[4].x[3] = 40;
        tbl[4].y[0] = 13; tbl[4].y[1] = 23; tbl[4].y[2] = 33; tbl[4].y[3] = 43;
        for (int k = 5; k < NTAB; k++) begin
            tbl[k].n = int'($urandom_range(1, DEPTH));
            tbl[k].use_last = (tbl[k].n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            tbl[k].lg = int'($urandom_range(0, 524287)) - 262144;
            tbl[k].mode = 2;
            for (int i = 0; i < 16; i++) begin
                tbl[k].x[i] = int'($urandom_range(0, 524287)) - 262144;
                tbl[k].y[i] = model(tbl[k].x[i], tbl[k].lg);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", int'(in_ready), 0);
        check("reset log_ready", int'(log_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", int'(in_ready), 1);

        for (int k = 0; k < NTAB; k++) begin
            send_vector(tbl[k]);
            send_log(tbl[k].lg);
            recv(tbl[k], tbl[k].n);
        end

        // Log held valid from the start of FILL, plus a score offered during DRAIN
        hv.n = 3; hv.use_last = 1; hv.lg = 7; hv.mode = 0;
        hv.x[0] = 100; hv.x[1] = -50; hv.x[2] = 7;
        for (int i = 0; i < 3; i++) hv.y[i] = model(hv.x[i], hv.lg);
        @(negedge clk);
        log_valid = 1'b1;
        log_in    = LOG_W'(7);
        send_vector(hv);
        in_valid = 1'b1; in_data = DATA_W'(99); in_last = 1'b1;
        send_log(7);
        recv(hv, hv.n);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("stalled score accepted", int'(log_ready), 1);
        hv.n = 1; hv.lg = 0; hv.y[0] = 99;
        send_log(0);
        recv(hv, 1);

        // Reset in the middle of DRAIN
        hv.n = 4; hv.lg = 1; hv.mode = 0;
        for (int i = 0; i < 4; i++) begin
            hv.x[i] = 50 * i;
            hv.y[i] = model(hv.x[i], 1);
        end
        send_vector(hv);
        send_log(1);
        recv(hv, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready while rst", int'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-drain reset out_valid", int'(out_valid), 0);
        check("mid-drain reset busy", int'(busy), 0);
        check("mid-drain reset in_ready", int'(in_ready), 1);
        hv.n = 1; hv.x[0] = 5; hv.lg = 2; hv.y[0] = 3;
        send_vector(hv);
        send_log(2);
        recv(hv, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
